// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board_io button/LED block.
package board_io_pkg;

    localparam int DefaultDebounceCycles = 6000;
    localparam int DefaultPwmWidth       = 8;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/board_io_if.sv
// Button and LED signal bundle between board_io and its user logic.
interface board_io_if
    import board_io_pkg::*;
#(
    parameter int NumBtn   = 3,
    parameter int NumLed   = 5,
    parameter int PwmWidth = DefaultPwmWidth
);

    logic [NumBtn-1:0]   btn_i;
    logic [NumBtn-1:0]   btn_o;
    logic [NumBtn-1:0]   btn_rise_o;
    logic [NumBtn-1:0]   btn_fall_o;
    logic [NumLed-1:0]   led_i;
    logic [PwmWidth-1:0] bright_i;
    logic [NumLed-1:0]   led_o;

    modport slave (
        input  btn_i, led_i, bright_i,
        output btn_o, btn_rise_o, btn_fall_o, led_o
    );

    modport master (
        output btn_i, led_i, bright_i,
        input  btn_o, btn_rise_o, btn_fall_o, led_o
    );

endinterface

// File: rtl/board_debounce.sv
// One button channel: 2-flop synchronizer, stability counter, press/release pulses.
module board_debounce
    import board_io_pkg::*;
#(
    parameter int DebounceCycles = DefaultDebounceCycles,
    parameter bit ActiveLow      = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CntW = cnt_width(DebounceCycles);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lvl_q, lvl_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            level;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // Synchronizer parks at the released pin level so release makes no pulse.
            sync_q <= {2{ActiveLow}};
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        level  = sync_q[1] ^ ActiveLow;
        cnt_d  = '0;
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (level != lvl_q) begin
            if (cnt_q == CntW'(DebounceCycles - 1)) begin
                lvl_d  = level;
                rise_d = level;
                fall_d = ~level;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign btn_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/board_io.sv
// Debounced buttons with edge pulses, and PWM-dimmed LED outputs sharing one phase.
module board_io
    import board_io_pkg::*;
#(
    parameter int              NumBtn         = 3,
    parameter int              NumLed         = 5,
    parameter int              DebounceCycles = DefaultDebounceCycles,
    parameter int              PwmWidth       = DefaultPwmWidth,
    parameter logic [NumBtn-1:0] BtnActiveLow = '0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    board_io_if.slave   io
);

    logic [NumBtn-1:0]   btn_lvl, btn_rise, btn_fall;
    logic [PwmWidth-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PwmWidth-1:0] shadow_q, shadow_d;
    logic [NumLed-1:0]   led_q, led_d;
    logic                pwm_on;

    for (genvar g = 0; g < NumBtn; g++) begin : g_btn
        board_debounce #(
            .DebounceCycles (DebounceCycles),
            .ActiveLow      (BtnActiveLow[g])
        ) u_debounce (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .btn_i  (io.btn_i[g]),
            .btn_o  (btn_lvl[g]),
            .rise_o (btn_rise[g]),
            .fall_o (btn_fall[g])
        );
    end

    assign io.btn_o      = btn_lvl;
    assign io.btn_rise_o = btn_rise;
    assign io.btn_fall_o = btn_fall;

    // Shadow only updates at the wrap so a brightness change never splits a period.
    always_comb begin
        pwm_on    = (shadow_q == '1) || (pwm_cnt_q < shadow_q);
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        shadow_d  = (pwm_cnt_q == '1) ? io.bright_i : shadow_q;
        led_d     = io.led_i & {NumLed{pwm_on}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_cnt_q <= '0;
            shadow_q  <= '0;
            led_q     <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
        end
    end

    assign io.led_o = led_q;

endmodule

// File: doc/board_io.md
BOARD_IO -- requirements
Module: board_io

Interface
REQ-001 SHALL have parameter NumBtn, default 3: number of button input channels, 1..32.
REQ-002 SHALL have parameter NumLed, default 5: number of LED output channels, 1..32.
REQ-003 SHALL have parameter DebounceCycles, default 6000 (1 ms at 6 MHz): stable cycles required before a button change is accepted, >=1.
REQ-004 SHALL have parameter PwmWidth, default 8: brightness/PWM counter width, 2..16.
REQ-005 SHALL have parameter BtnActiveLow, default all-zero, NumBtn bits: per-channel raw polarity, 1 = pressed when pin low.
REQ-006 SHALL have port clk_i  input  1  the single clock; all state is clocked on its rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port btn_i  input  NumBtn  raw, asynchronous button pins.
REQ-009 SHALL have port btn_o  output  NumBtn  debounced logical level, 1 = pressed.
REQ-010 SHALL have port btn_rise_o  output  NumBtn  one-cycle press pulse.
REQ-011 SHALL have port btn_fall_o  output  NumBtn  one-cycle release pulse.
REQ-012 SHALL have port led_i  input  NumLed  LED on/off request, from gpio_o.
REQ-013 SHALL have port bright_i  input  PwmWidth  global LED brightness.
REQ-014 SHALL have port led_o  output  NumLed  PWM-modulated LED drive, registered.

Function
REQ-015 Each btn_i bit SHALL pass through a 2-flop synchronizer, then be XORed with BtnActiveLow[i] to give the logical level.
REQ-016 Per channel, a counter of width $clog2(DebounceCycles+1) SHALL clear whenever the synchronized logical level equals btn_o[i].
REQ-017 The counter SHALL increment on every cycle the level differs from btn_o[i].
REQ-018 When the counter is at DebounceCycles-1 and the level still differs, btn_o[i] SHALL take the new level on the next edge and the counter SHALL clear.
REQ-019 A glitch shorter than DebounceCycles cycles SHALL never change btn_o; latency from a stable pin change to btn_o = 2 + DebounceCycles cycles.
REQ-020 btn_rise_o[i] or btn_fall_o[i] SHALL be high for exactly the first cycle btn_o[i] shows its new value; both SHALL never be high together.
REQ-021 Channels SHALL be independent; simultaneous changes on several channels SHALL each be handled per REQ-016..020.
REQ-022 A free-running PwmWidth-bit counter pwm_cnt SHALL increment every cycle and wrap from all-ones to 0.
REQ-023 A shadow brightness register SHALL load bright_i on the edge where pwm_cnt is all-ones; bright_i changes mid-period SHALL take effect only from the next pwm_cnt==0.
REQ-024 led_o[j] SHALL be registered as led_i[j] AND (shadow==all-ones OR pwm_cnt<shadow): shadow 0 = always off, all-ones = constantly on, otherwise duty shadow/2^PwmWidth.
REQ-025 led_i to led_o latency SHALL be 1 cycle; all led_o channels SHALL share one PWM phase.

Reset
REQ-026 Asserting rst_ni low SHALL immediately clear synchronizers to the inactive raw level (raw = BtnActiveLow[i]).
REQ-027 Asserting rst_ni low SHALL immediately clear debounce counters, btn_o, btn_rise_o, btn_fall_o, pwm_cnt, the shadow register and led_o to 0.
REQ-028 No edge pulse SHALL be generated by reset assertion or release; reset mid-debounce SHALL discard the partial count.
REQ-029 After release, LEDs SHALL stay off for the first 2^PwmWidth cycles, because the shadow is 0 until the first wrap.

Structure
REQ-030 A shared package board_io_pkg SHALL hold default constants (DefaultDebounceCycles, DefaultPwmWidth) and the counter-width helper.
REQ-031 One sub-module, board_debounce, SHALL implement the synchronizer, debounce counter and edge pulses for one channel; board_io SHALL instantiate it NumBtn times.
REQ-032 PWM logic SHALL live in board_io itself.

Verification (DebounceCycles=4, PwmWidth=4, NumBtn=3, BtnActiveLow=3'b001)
REQ-033 Bench SHALL check: hold btn_i[1] high 10 cycles -> btn_o[1]=1 exactly 6 cycles after the pin change, btn_rise_o[1] high 1 cycle.
REQ-034 Bench SHALL check: pulse btn_i[1] high for 3 cycles -> btn_o[1] stays 0, no pulses.
REQ-035 Bench SHALL check: btn_i[0] driven 0 after reset -> btn_o[0]=1 after 6 cycles; driven back to 1 -> btn_fall_o[0] pulses once.
REQ-036 Bench SHALL check: led_i=5'b11111, bright_i=4 -> each led_o high 4 of every 16 cycles; bright_i=0 -> always 0; bright_i=15 -> always 1.
REQ-037 Bench SHALL check: change bright_i from 4 to 12 at pwm_cnt=6 -> current period keeps duty 4, next period duty 12.
REQ-038 Bench SHALL check: assert rst_ni low at debounce count 2 with the pin held changed -> all outputs 0 immediately, no pulse; after release btn_o updates 6 cycles later.
